// File: rtl/mem_fill_pkg.sv
// Shared types and constants for the memory fill/check engine.
// State encoding, pattern mode codes and default widths.
package mem_fill_pkg;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ERRCNT_W = 8;

  localparam logic [1:0] MODE_CONST    = 2'd0;
  localparam logic [1:0] MODE_ADDR_XOR = 2'd1;
  localparam logic [1:0] MODE_INCR     = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;
endpackage

// File: rtl/mem_fill_pattern.sv
// Pattern generator shared by the write and compare paths.
// Reserved mode falls back to the constant seed.
module mem_fill_pattern
  import mem_fill_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_seed,
  input  logic [DATA_W-1:0] i_idx,
  input  logic [DATA_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data
);
  always_comb begin
    o_data = i_seed;
    case (i_mode)
      MODE_ADDR_XOR: o_data = i_addr ^ i_seed;
      MODE_INCR:     o_data = i_seed + i_idx;
      default:       o_data = i_seed;
    endcase
  end
endmodule

// File: rtl/mem_fill_checker.sv
// Fill a memory range with a pattern, read it back and compare.
// Reports pass/fail, first mismatch and a saturating error count.
module mem_fill_checker
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ERRCNT_W = DEF_ERRCNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W:0]     cfg_len,
  input  logic [1:0]          cfg_mode,
  input  logic [DATA_W-1:0]   cfg_seed,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                aborted,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [DATA_W-1:0]   err_exp,
  output logic [DATA_W-1:0]   err_got,
  output logic [ERRCNT_W-1:0] err_count
);
  localparam logic [ADDR_W:0]     IDX_ONE = 1;
  localparam logic [ERRCNT_W-1:0] ERR_ONE = 1;

  state_t              r_state;
  logic [ADDR_W:0]     r_idx;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_len;
  logic [1:0]          r_mode;
  logic [DATA_W-1:0]   r_seed;
  logic                r_pass;
  logic                r_aborted;
  logic [ADDR_W-1:0]   r_err_addr;
  logic [DATA_W-1:0]   r_err_exp;
  logic [DATA_W-1:0]   r_err_got;
  logic [ERRCNT_W-1:0] r_err_count;

  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_pat;
  logic                w_last;
  logic                w_mis;

  assign w_addr = r_base + r_idx[ADDR_W-1:0];
  assign w_last = (r_idx == r_len - IDX_ONE);
  assign w_mis  = (r_state == READ) && (mem_rdata != w_pat);

  mem_fill_pattern #(
    .DATA_W (DATA_W)
  ) u_pat (
    .i_mode (r_mode),
    .i_seed (r_seed),
    .i_idx  (r_idx[DATA_W-1:0]),
    .i_addr (w_addr[DATA_W-1:0]),
    .o_data (w_pat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_base      <= '0;
      r_len       <= '0;
      r_mode      <= MODE_CONST;
      r_seed      <= '0;
      r_pass      <= 1'b0;
      r_aborted   <= 1'b0;
      r_err_addr  <= '0;
      r_err_exp   <= '0;
      r_err_got   <= '0;
      r_err_count <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_base      <= cfg_base;
            r_len       <= cfg_len;
            r_mode      <= cfg_mode;
            r_seed      <= cfg_seed;
            r_idx       <= '0;
            r_aborted   <= 1'b0;
            r_err_addr  <= '0;
            r_err_exp   <= '0;
            r_err_got   <= '0;
            r_err_count <= '0;
            // An empty range completes at once and trivially passes.
            if (cfg_len == '0) begin
              r_pass  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_pass  <= 1'b0;
              r_state <= WRITE;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            r_state   <= IDLE;
            r_aborted <= 1'b1;
            r_pass    <= 1'b0;
          end else if (w_last) begin
            r_idx   <= '0;
            r_state <= READ;
          end else begin
            r_idx <= r_idx + IDX_ONE;
          end
        end
        READ: begin
          if (abort) begin
            r_state   <= IDLE;
            r_aborted <= 1'b1;
            r_pass    <= 1'b0;
          end else begin
            if (w_mis) begin
              if (r_err_count == '0) begin
                r_err_addr <= w_addr;
                r_err_exp  <= w_pat;
                r_err_got  <= mem_rdata;
              end
              if (r_err_count != '1)
                r_err_count <= r_err_count + ERR_ONE;
            end
            if (w_last) begin
              r_pass  <= (r_err_count == '0) && !w_mis;
              r_state <= DONE;
            end else begin
              r_idx <= r_idx + IDX_ONE;
            end
          end
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      WRITE: begin
        mem_wen   = 1'b1;
        mem_addr  = w_addr;
        mem_wdata = w_pat;
        busy      = 1'b1;
      end
      READ: begin
        mem_addr = w_addr;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      IDLE:    ;
    endcase
  end

  assign pass      = r_pass;
  assign aborted   = r_aborted;
  assign err_addr  = r_err_addr;
  assign err_exp   = r_err_exp;
  assign err_got   = r_err_got;
  assign err_count = r_err_count;
endmodule

// File: tb/tb_mem_fill_checker.sv
// Bench for mem_fill_checker: byte memory with optional bank
// aliasing fault, per-cycle expected-output queue, directed runs.
module tb_mem_fill_checker;
  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] cfg_base;
  logic [16:0] cfg_len;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_seed;
  logic        mem_wen;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy, done, pass, aborted;
  logic [15:0] err_addr;
  logic [7:0]  err_exp, err_got, err_count;

  always #5 clk = ~clk;

  mem_fill_checker dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_mode(cfg_mode), .cfg_seed(cfg_seed),
    .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .pass(pass), .aborted(aborted),
    .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got),
    .err_count(err_count)
  );

  logic [7:0] mem [0:65535];
  bit fault = 0;

  function automatic logic [15:0] alias_a(input logic [15:0] a);
    if (fault && a[15:14] == 2'b10) return {2'b01, a[13:0]};
    return a;
  endfunction

  always @(posedge clk)
    if (mem_wen === 1'b1) mem[alias_a(mem_addr)] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    bit        wen, busy, done, stat, pass, abt;
    bit [15:0] addr, ea;
    bit [7:0]  wdata, ee, eg, ec;
  } item_t;

  item_t q [$];
  int checks = 0;
  int failures = 0;
  logic [15:0] wlog_a [$];
  logic [7:0]  wlog_d [$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic item_t idle_item();
    item_t e;
    e = '{default: 0};
    return e;
  endfunction

  function automatic logic [7:0] pat(input logic [1:0] m,
      input logic [7:0] s, input int i, input logic [15:0] a);
    case (m)
      2'd1:    return a[7:0] ^ s;
      2'd2:    return s + 8'(i);
      default: return s;
    endcase
  endfunction

  // kind 0: full run; 1: abort after cycle `cut`; 2: reset after `cut`
  task automatic push_run(input logic [15:0] base, input int n,
      input logic [1:0] m, input logic [7:0] s, input int cut,
      input int kind);
    logic [7:0]  sh [int];
    logic [15:0] a [$];
    logic [7:0]  p [$];
    item_t L [$];
    item_t e;
    logic [7:0] g;
    int cnt = 0;
    e = idle_item();
    for (int i = 0; i < n; i++) begin
      a.push_back(base + 16'(i));
      p.push_back(pat(m, s, i, base + 16'(i)));
      sh[int'(alias_a(base + 16'(i)))] = pat(m, s, i, base + 16'(i));
    end
    for (int i = 0; i < n; i++) begin
      g = sh.exists(int'(a[i])) ? sh[int'(a[i])] : mem[a[i]];
      if (g != p[i]) begin
        if (cnt == 0) begin e.ea = a[i]; e.ee = p[i]; e.eg = g; end
        if (cnt < 255) cnt++;
      end
    end
    for (int i = 0; i < n; i++) begin
      item_t w = idle_item();
      w.wen = 1; w.busy = 1; w.addr = a[i]; w.wdata = p[i];
      L.push_back(w);
    end
    for (int i = 0; i < n; i++) begin
      item_t r = idle_item();
      r.busy = 1; r.addr = a[i];
      L.push_back(r);
    end
    e.done = 1; e.stat = 1; e.ec = 8'(cnt); e.pass = (cnt == 0);
    L.push_back(e);
    if (kind != 0) begin
      item_t t = idle_item();
      while (L.size() > cut) void'(L.pop_back());
      t.stat = 1; t.abt = (kind == 1);
      L.push_back(t);
    end
    foreach (L[k]) q.push_back(L[k]);
  endtask

  always @(negedge clk) begin
    item_t e;
    if (q.size() != 0) e = q.pop_front();
    else e = idle_item();
    chk("mem_wen", 32'(mem_wen), 32'(e.wen));
    chk("mem_addr", 32'(mem_addr), 32'(e.addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("done", 32'(done), 32'(e.done));
    if (e.stat) begin
      chk("pass", 32'(pass), 32'(e.pass));
      chk("aborted", 32'(aborted), 32'(e.abt));
      chk("err_addr", 32'(err_addr), 32'(e.ea));
      chk("err_exp", 32'(err_exp), 32'(e.ee));
      chk("err_got", 32'(err_got), 32'(e.eg));
      chk("err_count", 32'(err_count), 32'(e.ec));
    end
    if (mem_wen === 1'b1) begin
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_wdata);
    end
  end

  task automatic go(input logic [15:0] base, input int n,
      input logic [1:0] m, input logic [7:0] s, output int dcyc);
    @(negedge clk); #1;
    push_run(base, n, m, s, 0, 0);
    cfg_base = base; cfg_len = 17'(n); cfg_mode = m; cfg_seed = s;
    start = 1;
    dcyc = 0;
    for (int c = 1; c <= 2 * n + 4 && dcyc == 0; c++) begin
      @(negedge clk); #2;
      if (c == 1) begin
        start = 0;
        cfg_base = ~base; cfg_len = 17'h5; cfg_mode = ~m;
        cfg_seed = ~s;
      end
      if (done === 1'b1) dcyc = c;
    end
    chk("done_seen", 32'(dcyc != 0), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  int d;
  bit done_any;
  logic [15:0] xa [4];
  logic [7:0]  xd [4];

  initial begin
    rst = 1; start = 0; abort = 0;
    cfg_base = 0; cfg_len = 0; cfg_mode = 0; cfg_seed = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hFF;
    begin
      item_t z = idle_item();
      z.stat = 1;
      q.push_back(z);
    end
    repeat (3) @(negedge clk);
    #1 rst = 0;

    go(16'h0000, 4, 2'd0, 8'hA5, d);
    chk("t1_done_cycle", 32'(d), 32'd9);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_err_count", 32'(err_count), 32'd0);

    fault = 1;
    go(16'h8000, 2, 2'd2, 8'h10, d);
    fault = 0;
    chk("t2_pass", 32'(pass), 32'd0);
    chk("t2_err_count", 32'(err_count), 32'd2);
    chk("t2_err_addr", 32'(err_addr), 32'h8000);
    chk("t2_err_exp", 32'(err_exp), 32'h10);
    chk("t2_err_got", 32'(err_got), 32'hFF);

    wlog_a.delete(); wlog_d.delete();
    xa[0] = 16'hFFFE; xa[1] = 16'hFFFF; xa[2] = 16'h0000; xa[3] = 16'h0001;
    xd[0] = 8'hF1; xd[1] = 8'hF0; xd[2] = 8'h0F; xd[3] = 8'h0E;
    go(16'hFFFE, 4, 2'd1, 8'h0F, d);
    chk("t3_nwrites", 32'(wlog_a.size()), 32'd4);
    for (int i = 0; i < 4 && i < wlog_a.size(); i++) begin
      chk("t3_waddr", 32'(wlog_a[i]), 32'(xa[i]));
      chk("t3_wdata", 32'(wlog_d[i]), 32'(xd[i]));
    end
    chk("t3_pass", 32'(pass), 32'd1);

    wlog_a.delete(); wlog_d.delete();
    go(16'h1234, 0, 2'd0, 8'h55, d);
    chk("t4_done_cycle", 32'(d), 32'd1);
    chk("t4_pass", 32'(pass), 32'd1);
    chk("t4_nwrites", 32'(wlog_a.size()), 32'd0);

    @(negedge clk); #1;
    push_run(16'h0200, 8, 2'd2, 8'h40, 3, 1);
    cfg_base = 16'h0200; cfg_len = 17'd8; cfg_mode = 2'd2;
    cfg_seed = 8'h40; start = 1;
    done_any = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      if (done === 1'b1) done_any = 1;
      if (c == 1) start = 0;
      if (c == 2) start = 1;
      if (c == 3) begin start = 0; abort = 1; end
      if (c == 4) abort = 0;
    end
    chk("t5_no_done", 32'(done_any), 32'd0);
    chk("t5_aborted", 32'(aborted), 32'd1);
    chk("t5_pass", 32'(pass), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);

    @(negedge clk); #1;
    push_run(16'h0100, 4, 2'd0, 8'h3C, 6, 2);
    cfg_base = 16'h0100; cfg_len = 17'd4; cfg_mode = 2'd0;
    cfg_seed = 8'h3C; start = 1;
    done_any = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); #1;
      if (done === 1'b1) done_any = 1;
      if (c == 1) start = 0;
      if (c == 6) rst = 1;
      if (c == 7) rst = 0;
    end
    chk("t6_no_done", 32'(done_any), 32'd0);
    go(16'h0100, 4, 2'd1, 8'h77, d);
    chk("t6_done_cycle", 32'(d), 32'd9);
    chk("t6_pass", 32'(pass), 32'd1);
    chk("t6_aborted", 32'(aborted), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
